// File: rtl/output_sram_dma_reader_if.sv
// Bundles the output-SRAM DMA read port and the DMA write stream.
// Latency: none; this file holds only wires.
// Backpressure: dma_wready from the slave stalls the master's stream.
interface output_sram_dma_reader_if #(
    parameter int NUM_BANKS = 32,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
);
    // SRAM read-mux side: per-bank address, strobes and returned data
    logic [ADDR_W-1:0] output_SRAM_AB_DMA [0:NUM_BANKS-1];
    logic              output_SRAM_CEN_DMA;
    logic              output_SRAM_OEN_DMA;
    logic [DATA_W-1:0] output_SRAM_DO_DMA [0:NUM_BANKS-1];

    // DMA write stream toward external memory
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_wvalid;
    logic              dma_wready;
    logic              dma_wlast;

    // The read engine drives addresses/strobes and the stream
    modport master (
        output output_SRAM_AB_DMA,
        output output_SRAM_CEN_DMA,
        output output_SRAM_OEN_DMA,
        input  output_SRAM_DO_DMA,
        output dma_wdata,
        output dma_wvalid,
        output dma_wlast,
        input  dma_wready
    );

    // The SRAM mux and the DMA channel sit on the other side
    modport slave (
        input  output_SRAM_AB_DMA,
        input  output_SRAM_CEN_DMA,
        input  output_SRAM_OEN_DMA,
        output output_SRAM_DO_DMA,
        input  dma_wdata,
        input  dma_wvalid,
        input  dma_wlast,
        output dma_wready
    );
endinterface

// File: rtl/output_sram_dma_reader.sv
// Reads output-SRAM rows (all banks at once) into a line buffer and streams the words to DMA.
// Latency: 2 cycles per row before the first word; NUM_BANKS+2 cycles per row with wready high.
// Backpressure: dma_wready low freezes the stream (data/valid/last held); next row read waits for the last word.
module output_sram_dma_reader #(
    parameter int NUM_BANKS = 32,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     row_count,
    output logic                busy,
    output logic                done,
    output_sram_dma_reader_if.master bus
);

    localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W:0]  ONE_ROW  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic [ADDR_W-1:0]  row_ptr_q,   row_ptr_d;
    logic [ADDR_W:0]    rows_left_q, rows_left_d;
    logic [IDX_W-1:0]   word_idx_q,  word_idx_d;
    logic               busy_q,      busy_d;

    // One row worth of words, captured the cycle after the SRAM read
    logic [DATA_W-1:0]  line_q [0:NUM_BANKS-1];

    logic               handshake;
    logic               last_word;

    assign handshake = (state_q == S_STREAM) && bus.dma_wready;
    assign last_word = (word_idx_q == LAST_IDX);

    // State and counter registers; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_ptr_q   <= '0;
            rows_left_q <= '0;
            word_idx_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            rows_left_q <= rows_left_d;
            word_idx_q  <= word_idx_d;
            busy_q      <= busy_d;
        end
    end

    // Line buffer loads every bank's word while in CAPTURE (data is one cycle behind CEN)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                line_q[k] <= '0;
            end
        end else if (state_q == S_CAPTURE) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                line_q[k] <= bus.output_SRAM_DO_DMA[k];
            end
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        rows_left_d = rows_left_q;
        word_idx_d  = word_idx_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (row_count != '0) begin
                        row_ptr_d   = start_addr;
                        rows_left_d = row_count;
                        busy_d      = 1'b1;
                        state_d     = S_READ;
                    end else begin
                        // Empty transfer: report completion without touching the SRAM
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                word_idx_d = '0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (handshake) begin
                    if (last_word) begin
                        word_idx_d = '0;
                        if (rows_left_q == ONE_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            rows_left_d = rows_left_q - ONE_ROW;
                            // Row pointer wraps naturally at 2^ADDR_W
                            row_ptr_d   = row_ptr_q + 1'b1;
                            state_d     = S_READ;
                        end
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: strobes, stream and status follow the current state
    always_comb begin
        bus.output_SRAM_CEN_DMA = 1'b1;
        bus.output_SRAM_OEN_DMA = 1'b1;
        bus.dma_wvalid          = 1'b0;
        bus.dma_wdata           = '0;
        bus.dma_wlast           = 1'b0;
        done                    = 1'b0;
        case (state_q)
            S_READ: begin
                bus.output_SRAM_CEN_DMA = 1'b0;
                bus.output_SRAM_OEN_DMA = 1'b0;
            end
            S_CAPTURE: begin
                bus.output_SRAM_OEN_DMA = 1'b0;
            end
            S_STREAM: begin
                bus.dma_wvalid = 1'b1;
                bus.dma_wdata  = line_q[word_idx_q];
                bus.dma_wlast  = last_word && (rows_left_q == ONE_ROW);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Row pointer only moves when entering READ, so it doubles as the held bank address
    always_comb begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            bus.output_SRAM_AB_DMA[k] = row_ptr_q;
        end
    end

    assign busy = busy_q;

endmodule

// File: doc/output_sram_dma_reader.md
Name: output_sram_dma_reader

Overview:
- DMA-side read engine for the 32-bank output SRAM.
- Drives the DMA inputs of the output SRAM read mux (address, CEN, OEN) and consumes the returned read data.
- Each access reads one row (same address in all 32 banks) into a 32-word line buffer, then streams the words one per handshake to the DMA write channel toward external memory.
- System controller holds mux select = 0 (DMA) whenever busy = 1.

Parameters:
- NUM_BANKS, 32, number of output SRAM banks read in parallel per row.
- ADDR_W, 12, SRAM row address width.
- DATA_W, 32, SRAM word width and DMA stream data width.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- start_addr  input  ADDR_W  first row address.
- row_count  input  ADDR_W+1  rows to transfer, 0..4096.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- output_SRAM_AB_DMA  output  ADDR_W x NUM_BANKS (unpacked [0:NUM_BANKS-1])  per-bank row address, all banks identical.
- output_SRAM_CEN_DMA  output  1  chip enable, active-low.
- output_SRAM_OEN_DMA  output  1  output enable, active-low.
- output_SRAM_DO_DMA  input  DATA_W x NUM_BANKS (unpacked)  read data, valid one cycle after the CEN-low cycle.
- dma_wdata  output  DATA_W  stream word.
- dma_wvalid  output  1  stream valid.
- dma_wready  input  1  stream ready.
- dma_wlast  output  1  marks final word of the whole transfer.

Behaviour:
- Reset values (async, immediate): all AB = 0, CEN = 1, OEN = 1, busy = 0, done = 0, dma_wvalid = 0, dma_wdata = 0, dma_wlast = 0, state = IDLE, row/word counters = 0.
- State machine:
  - IDLE: on start with row_count != 0: latch start_addr into row_ptr, latch row_count into rows_left, busy <= 1, go to READ. On start with row_count == 0: done pulses the next cycle, busy stays 0, no SRAM access. start in any other state is ignored.
  - READ, 1 cycle: CEN = 0, OEN = 0, all AB = row_ptr. Go to CAPTURE.
  - CAPTURE, 1 cycle: CEN = 1, OEN = 0; latch all 32 output_SRAM_DO_DMA words into the line buffer; word_idx <= 0. Go to STREAM.
  - STREAM: dma_wvalid = 1, dma_wdata = buf[word_idx]. Each cycle with wvalid && wready: word_idx++. On the handshake with word_idx = NUM_BANKS-1:
    - rows_left == 1: go to DONE.
    - otherwise: rows_left--, row_ptr <= row_ptr + 1 (mod 2^ADDR_W, so 4095 wraps to 0), go to READ.
  - DONE, 1 cycle: done = 1, busy <= 0, wvalid = 0. Go to IDLE.
- CEN/OEN are high in all states except those listed above. AB holds its last value outside READ.
- While wready = 0 in STREAM, wdata, wvalid and wlast hold stable. wvalid never drops before a handshake.
- dma_wlast = 1 only while streaming word NUM_BANKS-1 of the final row.
- Minimum per-row cost: 2 + NUM_BANKS cycles. With wready tied high, a full transfer takes row_count*(NUM_BANKS+2) cycles from start to the DONE state.
- Reset asserted mid-transfer aborts immediately to reset values. No done pulse; the partial stream is not completed.
- row_count = 4096 transfers every row, with row_ptr wrapping.

Test Plan:
- Reset: assert rst mid-cycle -> CEN = 1, OEN = 1, wvalid = 0, busy = 0 asynchronously, before the next clk edge.
- Single row: start_addr = 0x010, row_count = 1, SRAM model returns bank k word = 0xA0000000+k, wready = 1 -> one CEN-low cycle with AB = 0x010 on all 32 banks; 32 words 0xA0000000..0xA000001F in bank order; wlast on the 32nd word; done 1 cycle later; 34 cycles start-to-DONE.
- Backpressure: row_count = 2, wready toggling 1,0,0,1,... -> 64 words in order, no loss or duplication, wdata stable while wready = 0, second READ at AB = 0x011 only after word 31 of row 0 is accepted.
- Wrap: start_addr = 0xFFF, row_count = 2 -> READ addresses 0xFFF then 0x000.
- Zero length: row_count = 0 -> done pulse one cycle after start, CEN never low, busy never high.
- Ignored start: pulse start again during STREAM with different start_addr -> no effect; original transfer completes unchanged.
